mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//  Iterative MULT/MULTU/DIV/DIVU engine that owns the HI/LO architectural registers.
//  Sits downstream of register_file: consumes rs/rt operands and replaces the reg_hi/reg_lo pair.
//  Drives busy so mips_cpu_harvard can stall MFHI/MFLO/mult/div until results are ready.
// PARAMETERS
//  WIDTH  32  operand width; hi/lo are WIDTH each; iteration count = WIDTH
// PORTS
//  clk           in   1      system clock, rising edge
//  reset         in   1      synchronous, active-high
//  start         in   1      request op; sampled only when busy=0
//  op            in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  a             in   WIDTH  rs (multiplicand / dividend)
//  b             in   WIDTH  rt (multiplier / divisor)
//  hi_wren       in   1      MTHI: hi <= wdata
//  lo_wren       in   1      MTLO: lo <= wdata
//  wdata         in   WIDTH  MTHI/MTLO data (rs)
//  busy          out  1      operation in flight
//  done          out  1      one-cycle pulse: hi/lo just updated by op
//  div_by_zero   out  1      sticky per op: last divide had b==0
//  hi            out  WIDTH  HI register
//  lo            out  WIDTH  LO register
// BEHAVIOUR
//  Reset: state=IDLE, hi=lo=0, busy=0, done=0, div_by_zero=0, counter=0.
//  Reset mid-operation aborts: IDLE next cycle, no done pulse, hi/lo forced to 0.
//  FSM: IDLE -> RUN (start & !busy at edge E0; a, b, op captured; abs values taken for signed)
//       RUN: one shift-add (mul) / restoring shift-subtract (div) step per cycle, WIDTH cycles
//       RUN -> FIXUP after WIDTH steps; FIXUP applies sign correction, writes hi/lo -> IDLE
//  Latency: start sampled at E0; hi/lo written at E(WIDTH+1)=E33; done=1 for the cycle after E33.
//  busy=1 from cycle after E0 through cycle ending at E33 (state != IDLE); done and busy never both 1.
//  start while busy=1: ignored, no queuing. op/a/b changes after E0 have no effect.
//  Multiply: 2*WIDTH product; hi=upper, lo=lower. Signed: negate product if a[31]^b[31].
//  Divide: lo=quotient, hi=remainder. Signed: quotient negated if a[31]^b[31];
//    remainder takes sign of dividend (truncating division, C semantics).
//  Divide by zero: same latency; hi=a, lo={WIDTH{1'b1}}, div_by_zero=1. Cleared at next accepted start.
//  Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0, div_by_zero=0.
//  MTHI/MTLO: write at edge when busy=0; ignored when busy=1 (CPU stalls on busy).
//  Same-edge start and hi/lo_wren: register write applies at E0, then overwritten at E33.
//  hi/lo hold value between writes; outputs registered, no combinational path from inputs.
// CONFIGURATION
//  MULT_DIV_FAST_MUL_EN defined: MULT/MULTU computed in one cycle via single WIDTH x WIDTH
//    multiplier; start at E0 -> hi/lo written at E0, done=1 the cycle after E0, busy stays 0.
//    DIV/DIVU unchanged (iterative, 33 cycles).
//  Undefined (default): all four ops iterative with 33-cycle latency as above.
// TESTING
//  MULT a=0xFFFFFFFF b=2 -> done 33 cyc after start; hi=0xFFFFFFFF lo=0xFFFFFFFE.
//  MULTU a=0xFFFFFFFF b=2 -> hi=0x00000001 lo=0xFFFFFFFE; busy high exactly 33 cycles.
//  DIV a=-7 (0xFFFFFFF9) b=2 -> lo=0xFFFFFFFD (-3) hi=0xFFFFFFFF (-1); DIVU same -> lo=0x7FFFFFFC hi=1.
//  DIVU a=100 b=0 -> hi=0x64 lo=0xFFFFFFFF div_by_zero=1; next MULT clears div_by_zero.
//  Start MULTU 3*5, pulse start again with DIV at cycle 5, reset at cycle 10 -> second start ignored;
//    busy=0, hi=lo=0 after reset edge, no done pulse; then MTLO 0x1234 -> lo=0x1234 next cycle.
//  With MULT_DIV_FAST_MUL_EN: MULT 6*-7 -> done 1 cycle after start, hi=0xFFFFFFFF lo=0xFFFFFFD6, busy=0.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine owning the HI/LO registers.
// Define MULT_DIV_FAST_MUL_EN for single-cycle MULT/MULTU; divides stay iterative.
module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_wren,
    input  logic             lo_wren,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned W2   = 2 * WIDTH;

    typedef enum logic [1:0] {StIdle, StRun, StFixup} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [1:0]        op_q, op_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]  babs_q, babs_d;
    logic [WIDTH-1:0]  acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0]  hi_q, hi_d, lo_q, lo_d;
    logic              done_q, done_d, dbz_q, dbz_d;

    logic [WIDTH-1:0]  a_abs, b_abs;
    logic [WIDTH:0]    mul_sum, div_shift, div_diff;
    logic [W2-1:0]     prod, prod_fix;
    logic              mul_neg, quo_neg, rem_neg;

    // Signed ops run on magnitudes; signs are restored in StFixup from the captured operands.
    assign a_abs = (!op[0] && a[WIDTH-1]) ? -a : a;
    assign b_abs = (!op[0] && b[WIDTH-1]) ? -b : b;

    assign mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, babs_q} : '0);
    assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, babs_q};

    assign prod     = {acc_hi_q, acc_lo_q};
    assign mul_neg  = !op_q[0] && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
    assign quo_neg  = mul_neg;
    assign rem_neg  = !op_q[0] && a_q[WIDTH-1];
    assign prod_fix = mul_neg ? -prod : prod;

`ifdef MULT_DIV_FAST_MUL_EN
    logic signed [W2-1:0] fa_s, fb_s;
    logic [W2-1:0]        fast_prod_s, fast_prod_u, fast_prod;
    assign fa_s        = {{WIDTH{a[WIDTH-1]}}, a};
    assign fb_s        = {{WIDTH{b[WIDTH-1]}}, b};
    assign fast_prod_s = fa_s * fb_s;
    assign fast_prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    assign fast_prod   = op[0] ? fast_prod_u : fast_prod_s;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        babs_d   = babs_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dbz_d    = dbz_q;
        done_d   = 1'b0;

        case (state_q)
            StIdle: begin
                if (hi_wren) hi_d = wdata;
                if (lo_wren) lo_d = wdata;
                if (start) begin
                    dbz_d    = 1'b0;
                    op_d     = op;
                    a_d      = a;
                    b_d      = b;
                    babs_d   = b_abs;
                    acc_hi_d = '0;
                    acc_lo_d = a_abs;
                    cnt_d    = '0;
                    state_d  = StRun;
`ifdef MULT_DIV_FAST_MUL_EN
                    if (!op[1]) begin
                        hi_d    = fast_prod[W2-1:WIDTH];
                        lo_d    = fast_prod[WIDTH-1:0];
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end
`endif
                end
            end
            StRun: begin
                cnt_d = cnt_q + 1'b1;
                if (op_q[1]) begin
                    // Restoring step: keep the trial difference only when it did not borrow.
                    if (!div_diff[WIDTH]) begin
                        acc_hi_d = div_diff[WIDTH-1:0];
                        acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_hi_d = div_shift[WIDTH-1:0];
                        acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_hi_d = mul_sum[WIDTH:1];
                    acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
                end
                if (cnt_q == CntW'(WIDTH - 1)) state_d = StFixup;
            end
            StFixup: begin
                state_d = StIdle;
                done_d  = 1'b1;
                if (!op_q[1]) begin
                    hi_d = prod_fix[W2-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end else if (b_q == '0) begin
                    hi_d  = a_q;
                    lo_d  = '1;
                    dbz_d = 1'b1;
                end else begin
                    lo_d = quo_neg ? -acc_lo_q : acc_lo_q;
                    hi_d = rem_neg ? -acc_hi_q : acc_hi_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            babs_q   <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            babs_q   <= babs_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end

    assign busy        = (state_q != StIdle);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: vector table, random ops vs. arithmetic model,
// and hand-written abort / MTHI / MTLO sequences.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset, start, hi_wren, lo_wren;
    logic [1:0]  op;
    logic [31:0] a, b, wdata;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int n_tests = 0;
    int n_fail  = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .hi_wren(hi_wren), .lo_wren(lo_wren), .wdata(wdata),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model straight from the arithmetic definitions.
    task automatic model(input logic [1:0] mop, input logic [31:0] ma, input logic [31:0] mb,
                         output logic [31:0] mhi, output logic [31:0] mlo, output logic mdbz);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa   = longint'($signed(ma));
        sb   = longint'($signed(mb));
        mdbz = 1'b0;
        p    = '0;
        q    = 0;
        r    = 0;
        case (mop)
            2'd0: p = 64'(sa * sb);
            2'd1: p = {32'd0, ma} * {32'd0, mb};
            default: begin
                if (mb == 32'd0) begin
                    mdbz = 1'b1;
                    p    = {ma, 32'hFFFF_FFFF};
                end else begin
                    if (mop == 2'd2) begin
                        q = sa / sb;
                        r = sa % sb;
                    end else begin
                        q = longint'({32'd0, ma}) / longint'({32'd0, mb});
                        r = longint'({32'd0, ma}) % longint'({32'd0, mb});
                    end
                    p = {r[31:0], q[31:0]};
                end
            end
        endcase
        mhi = p[63:32];
        mlo = p[31:0];
    endtask

    function automatic int exp_latency(input logic [1:0] lop);
`ifdef MULT_DIV_FAST_MUL_EN
        return lop[1] ? 33 : 0;
`else
        return 33;
`endif
    endfunction

    // Issue one op from idle (called #1 after an edge) and check timing and results.
    task automatic run_op(input string tag, input logic [1:0] rop, input logic [31:0] ra,
                          input logic [31:0] rb, input logic [31:0] ehi,
                          input logic [31:0] elo, input logic edbz);
        int lat, bcnt, overlap;
        op    = rop;
        a     = ra;
        b     = rb;
        start = 1'b1;
        tick();
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        op    = 2'($urandom_range(0, 3));
        lat     = 0;
        bcnt    = 0;
        overlap = 0;
        while (!done && lat < 100) begin
            if (busy) bcnt++;
            tick();
            lat++;
            if (done && busy) overlap++;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_latency(rop)));
        check({tag, " busy cycles"}, 32'(bcnt), 32'(exp_latency(rop)));
        check({tag, " done&busy overlap"}, 32'(overlap), 32'd0);
        check({tag, " hi"}, hi, ehi);
        check({tag, " lo"}, lo, elo);
        check({tag, " div_by_zero"}, 32'(div_by_zero), 32'(edbz));
        tick();
        check({tag, " done pulse width"}, 32'(done), 32'd0);
    endtask

    vec_t vecs[12];

    initial begin
        logic [31:0] mhi, mlo;
        logic        mdbz;
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        int          seen_done;

        vecs[0]  = '{2'd0, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
        vecs[1]  = '{2'd1, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0};
        vecs[2]  = '{2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[3]  = '{2'd3, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 32'h7FFF_FFFC, 1'b0};
        vecs[4]  = '{2'd3, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1};
        vecs[5]  = '{2'd0, 32'd3, 32'd5, 32'h0000_0000, 32'h0000_000F, 1'b0};
        vecs[6]  = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
        vecs[7]  = '{2'd2, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
        vecs[8]  = '{2'd2, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1};
        vecs[9]  = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[10] = '{2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
        vecs[11] = '{2'd0, 32'd6, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 1'b0};

        reset   = 1'b1;
        start   = 1'b0;
        op      = 2'd0;
        a       = '0;
        b       = '0;
        hi_wren = 1'b0;
        lo_wren = 1'b0;
        wdata   = '0;
        repeat (3) tick();
        reset = 1'b0;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset div_by_zero", 32'(div_by_zero), 32'd0);
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);

        for (int i = 0; i < 12; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].hi, vecs[i].lo, vecs[i].dbz);
        end

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 17));
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            model(rop, ra, rb, mhi, mlo, mdbz);
            run_op($sformatf("rnd%0d op%0d a=%h b=%h", i, rop, ra, rb), rop, ra, rb,
                   mhi, mlo, mdbz);
        end

        // MTHI/MTLO while idle, then MTHI ignored while busy.
        hi_wren = 1'b1;
        wdata   = 32'h0000_AAAA;
        tick();
        hi_wren = 1'b0;
        check("mthi idle", hi, 32'h0000_AAAA);
        op    = 2'd3;
        a     = 32'd50;
        b     = 32'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        hi_wren = 1'b1;
        wdata   = 32'h0000_5555;
        tick();
        hi_wren = 1'b0;
        check("mthi while busy ignored", hi, 32'h0000_AAAA);
        for (int k = 0; k < 100 && !done; k++) tick();
        check("divu 50/7 lo", lo, 32'd7);
        check("divu 50/7 hi", hi, 32'd1);
        tick();

        // Same-edge start and MTLO: write lands at E0, result overwrites at the end.
        op      = 2'd3;
        a       = 32'd10;
        b       = 32'd3;
        start   = 1'b1;
        lo_wren = 1'b1;
        wdata   = 32'h0000_DEAD;
        tick();
        start   = 1'b0;
        lo_wren = 1'b0;
        check("same-edge mtlo at E0", lo, 32'h0000_DEAD);
        for (int k = 0; k < 100 && !done; k++) tick();
        check("same-edge final lo", lo, 32'd3);
        check("same-edge final hi", hi, 32'd1);
        tick();

        // Abort: MULTU in flight, ignored second start, then reset at cycle 10.
        hi_wren = 1'b1;
        lo_wren = 1'b1;
        wdata   = 32'h77;
        tick();
        hi_wren = 1'b0;
        lo_wren = 1'b0;
        op      = 2'd1;
        a       = 32'd3;
        b       = 32'd5;
        start   = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        op    = 2'd2;
        a     = 32'd9;
        b     = 32'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
`ifndef MULT_DIV_FAST_MUL_EN
        check("abort still busy after ignored start", 32'(busy), 32'd1);
`endif
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort hi", hi, 32'd0);
        check("abort lo", lo, 32'd0);
        seen_done = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (done || busy) seen_done++;
        end
        check("abort no later done/busy", 32'(seen_done), 32'd0);
        lo_wren = 1'b1;
        wdata   = 32'h0000_1234;
        tick();
        lo_wren = 1'b0;
        check("mtlo after abort", lo, 32'h0000_1234);
        tick();
        check("lo holds", lo, 32'h0000_1234);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
